// File: rtl/frame_buffer_manager_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_buffer_manager_pkg
//  Description : Shared types and reset constants for the triple-buffer manager.
//  Revision    : 1.0 - initial release
// ============================================================================
package frame_buffer_manager_pkg;

    typedef logic [1:0] buf_idx_t;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_BUSY = 1'b1
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_BUSY = 1'b1
    } rd_state_t;

    localparam buf_idx_t c_rst_wr_idx    = 2'd0;
    localparam buf_idx_t c_rst_ready_idx = 2'd1;
    localparam buf_idx_t c_rst_rd_idx    = 2'd2;

endpackage
`default_nettype wire

// File: rtl/frame_buffer_manager.sv
`default_nettype none
// ============================================================================
//  Module      : frame_buffer_manager
//  Description : Triple-buffer arbiter between an HDMI capture writer and a DSI
//                reader; hands out registered frame base addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_buffer_manager
    import frame_buffer_manager_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] FRAME_BYTES = 32'h000E_1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        wr_frame_start,
    input  logic        wr_frame_done,
    input  logic        rd_frame_start,
    input  logic        rd_frame_done,
    output logic [31:0] wr_base_addr,
    output logic        wr_base_valid,
    output logic [31:0] rd_base_addr,
    output logic        rd_base_valid,
    output logic        rd_repeat,
    output logic [15:0] dropped_cnt
);

    localparam logic [31:0] c_addr_0 = BASE_ADDR;
    localparam logic [31:0] c_addr_1 = BASE_ADDR + FRAME_BYTES;
    localparam logic [31:0] c_addr_2 = BASE_ADDR + (FRAME_BYTES << 1);

    function automatic logic [31:0] idx_addr(input buf_idx_t idx);
        case (idx)
            2'd1:    idx_addr = c_addr_1;
            2'd2:    idx_addr = c_addr_2;
            default: idx_addr = c_addr_0;
        endcase
    endfunction

    buf_idx_t    r_wr_idx, r_ready_idx, r_rd_idx;
    logic        r_fresh, r_have_frame;
    wr_state_t   r_wr_state;
    rd_state_t   r_rd_state;
    logic [15:0] r_dropped_cnt;
    logic [31:0] r_wr_base_addr, r_rd_base_addr;
    logic        r_wr_base_valid, r_rd_base_valid, r_rd_repeat;

    buf_idx_t    w_wr_idx, w_ready_idx, w_rd_idx;
    logic        w_fresh, w_have_frame, w_drop;
    wr_state_t   w_wr_state;
    rd_state_t   w_rd_state;
    logic        w_rd_valid, w_rd_repeat;

    // Writer resolves first so a same-cycle read picks up the frame just completed.
    always_comb begin
        w_wr_idx     = r_wr_idx;
        w_ready_idx  = r_ready_idx;
        w_rd_idx     = r_rd_idx;
        w_fresh      = r_fresh;
        w_have_frame = r_have_frame;
        w_wr_state   = r_wr_state;
        w_rd_state   = r_rd_state;
        w_drop       = 1'b0;
        w_rd_valid   = r_rd_base_valid;
        w_rd_repeat  = r_rd_repeat;

        if (r_wr_state == W_BUSY && wr_frame_done) begin
            w_wr_idx     = r_ready_idx;
            w_ready_idx  = r_wr_idx;
            w_fresh      = 1'b1;
            w_have_frame = 1'b1;
            w_drop       = r_fresh;
            w_wr_state   = W_IDLE;
        end
        if (wr_frame_start) begin
            w_wr_state = W_BUSY;
        end

        if (rd_frame_start) begin
            w_rd_state = R_BUSY;
            w_rd_valid = w_have_frame;
            if (w_fresh) begin
                w_rd_idx    = w_ready_idx;
                w_ready_idx = r_rd_idx;
                w_fresh     = 1'b0;
                w_rd_repeat = 1'b0;
            end else begin
                w_rd_repeat = 1'b1;
            end
        end else if (rd_frame_done) begin
            w_rd_state = R_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        // Drop counter survives enable=0; only a real reset clears it.
        if (!rst_n) begin
            r_dropped_cnt <= 16'h0000;
        end else if (enable && w_drop && r_dropped_cnt != 16'hFFFF) begin
            r_dropped_cnt <= r_dropped_cnt + 16'd1;
        end

        if (!rst_n || !enable) begin
            r_wr_idx        <= c_rst_wr_idx;
            r_ready_idx     <= c_rst_ready_idx;
            r_rd_idx        <= c_rst_rd_idx;
            r_fresh         <= 1'b0;
            r_have_frame    <= 1'b0;
            r_wr_state      <= W_IDLE;
            r_rd_state      <= R_IDLE;
            r_wr_base_addr  <= c_addr_0;
            r_wr_base_valid <= 1'b0;
            r_rd_base_addr  <= c_addr_2;
            r_rd_base_valid <= 1'b0;
            r_rd_repeat     <= 1'b0;
        end else begin
            r_wr_idx        <= w_wr_idx;
            r_ready_idx     <= w_ready_idx;
            r_rd_idx        <= w_rd_idx;
            r_fresh         <= w_fresh;
            r_have_frame    <= w_have_frame;
            r_wr_state      <= w_wr_state;
            r_rd_state      <= w_rd_state;
            r_wr_base_addr  <= idx_addr(w_wr_idx);
            r_wr_base_valid <= (w_wr_state == W_BUSY);
            r_rd_base_addr  <= idx_addr(w_rd_idx);
            r_rd_base_valid <= w_rd_valid;
            r_rd_repeat     <= w_rd_repeat;
        end
    end

    assign wr_base_addr  = r_wr_base_addr;
    assign wr_base_valid = r_wr_base_valid;
    assign rd_base_addr  = r_rd_base_addr;
    assign rd_base_valid = r_rd_base_valid;
    assign rd_repeat     = r_rd_repeat;
    assign dropped_cnt   = r_dropped_cnt;

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_manager.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_buffer_manager
//  Description : Directed scoreboard bench for frame_buffer_manager.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_buffer_manager;

    localparam logic [31:0] c_a0 = 32'h0000_0000;
    localparam logic [31:0] c_a1 = 32'h000E_1000;
    localparam logic [31:0] c_a2 = 32'h001C_2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        wr_frame_start = 1'b0, wr_frame_done = 1'b0;
    logic        rd_frame_start = 1'b0, rd_frame_done = 1'b0;
    logic [31:0] wr_base_addr, rd_base_addr;
    logic        wr_base_valid, rd_base_valid, rd_repeat;
    logic [15:0] dropped_cnt;

    frame_buffer_manager #(
        .BASE_ADDR   (32'h0000_0000),
        .FRAME_BYTES (32'h000E_1000)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .wr_frame_start (wr_frame_start),
        .wr_frame_done  (wr_frame_done),
        .rd_frame_start (rd_frame_start),
        .rd_frame_done  (rd_frame_done),
        .wr_base_addr   (wr_base_addr),
        .wr_base_valid  (wr_base_valid),
        .rd_base_addr   (rd_base_addr),
        .rd_base_valid  (rd_base_valid),
        .rd_repeat      (rd_repeat),
        .dropped_cnt    (dropped_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        string       name;
        logic [31:0] wa;
        logic        wv;
        logic [31:0] ra;
        logic        rv;
        logic        rr;
        logic [15:0] dc;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string step, input string what,
                       input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s %s: got %h expected %h", step, what, act, req);
        end
    endtask

    // Monitor: outputs are registered, so each vector is due one edge after it is driven.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (q.size() > 0 && q[0].due == cyc) begin
            m_e = q.pop_front();
            chk(m_e.name, "wr_base_addr",  wr_base_addr,          m_e.wa);
            chk(m_e.name, "wr_base_valid", {31'd0, wr_base_valid}, {31'd0, m_e.wv});
            chk(m_e.name, "rd_base_addr",  rd_base_addr,          m_e.ra);
            chk(m_e.name, "rd_base_valid", {31'd0, rd_base_valid}, {31'd0, m_e.rv});
            chk(m_e.name, "rd_repeat",     {31'd0, rd_repeat},     {31'd0, m_e.rr});
            chk(m_e.name, "dropped_cnt",   {16'd0, dropped_cnt},   {16'd0, m_e.dc});
        end
    end

    task automatic step(input string name, input logic rn, input logic en,
                        input logic ws, input logic wd, input logic rs, input logic rd,
                        input logic [31:0] wa, input logic wv, input logic [31:0] ra,
                        input logic rv, input logic rr, input logic [15:0] dc);
        exp_t e;
        @(negedge clk);
        rst_n          = rn;
        enable         = en;
        wr_frame_start = ws;
        wr_frame_done  = wd;
        rd_frame_start = rs;
        rd_frame_done  = rd;
        e.due  = cyc + 1;
        e.name = name;
        e.wa = wa; e.wv = wv; e.ra = ra; e.rv = rv; e.rr = rr; e.dc = dc;
        q.push_back(e);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        //    name        rn en ws wd rs rd   wa    wv  ra    rv rr dc
        step("reset",     0, 1, 0, 0, 0, 0, c_a0, 0, c_a2, 0, 0, 16'd0);
        step("wstart1",   1, 1, 1, 0, 0, 0, c_a0, 1, c_a2, 0, 0, 16'd0);
        step("idle1",     1, 1, 0, 0, 0, 0, c_a0, 1, c_a2, 0, 0, 16'd0);
        step("wdone1",    1, 1, 0, 1, 0, 0, c_a1, 0, c_a2, 0, 0, 16'd0);
        step("rstart1",   1, 1, 0, 0, 1, 0, c_a1, 0, c_a0, 1, 0, 16'd0);
        step("wstart2",   1, 1, 1, 0, 0, 0, c_a1, 1, c_a0, 1, 0, 16'd0);
        step("rdone1",    1, 1, 0, 0, 0, 1, c_a1, 1, c_a0, 1, 0, 16'd0);
        step("wdone2",    1, 1, 0, 1, 0, 0, c_a2, 0, c_a0, 1, 0, 16'd0);
        step("rstart2",   1, 1, 0, 0, 1, 0, c_a2, 0, c_a1, 1, 0, 16'd0);
        step("rrepeat",   1, 1, 0, 0, 1, 0, c_a2, 0, c_a1, 1, 1, 16'd0);
        step("wstart3",   1, 1, 1, 0, 0, 0, c_a2, 1, c_a1, 1, 1, 16'd0);
        step("wdone3",    1, 1, 0, 1, 0, 0, c_a0, 0, c_a1, 1, 1, 16'd0);
        step("wstart4",   1, 1, 1, 0, 0, 0, c_a0, 1, c_a1, 1, 1, 16'd0);
        step("wdone4",    1, 1, 0, 1, 0, 0, c_a2, 0, c_a1, 1, 1, 16'd1);
        step("wstart5",   1, 1, 1, 0, 0, 0, c_a2, 1, c_a1, 1, 1, 16'd1);
        step("wdone5",    1, 1, 0, 1, 0, 0, c_a0, 0, c_a1, 1, 1, 16'd2);
        step("rlatest",   1, 1, 0, 0, 1, 0, c_a0, 0, c_a2, 1, 0, 16'd2);
        step("wdoneidle", 1, 1, 0, 1, 0, 0, c_a0, 0, c_a2, 1, 0, 16'd2);
        step("wstart6",   1, 1, 1, 0, 0, 0, c_a0, 1, c_a2, 1, 0, 16'd2);
        step("wabort",    1, 1, 1, 0, 0, 0, c_a0, 1, c_a2, 1, 0, 16'd2);
        step("wdone6",    1, 1, 0, 1, 0, 0, c_a1, 0, c_a2, 1, 0, 16'd2);
        step("wstart7",   1, 1, 1, 0, 0, 0, c_a1, 1, c_a2, 1, 0, 16'd2);
        step("samecycle", 1, 1, 0, 1, 1, 0, c_a0, 0, c_a1, 1, 0, 16'd3);
        step("rrepeat2",  1, 1, 0, 0, 1, 0, c_a0, 0, c_a1, 1, 1, 16'd3);
        step("disable",   1, 0, 1, 0, 0, 0, c_a0, 0, c_a2, 0, 0, 16'd3);
        step("rnoframe",  1, 1, 0, 0, 1, 0, c_a0, 0, c_a2, 0, 1, 16'd3);
        step("wstart8",   1, 1, 1, 0, 0, 0, c_a0, 1, c_a2, 0, 1, 16'd3);
        step("midreset",  0, 1, 0, 0, 0, 0, c_a0, 0, c_a2, 0, 0, 16'd0);
        step("rnoframe2", 1, 1, 0, 0, 1, 0, c_a0, 0, c_a2, 0, 1, 16'd0);
        @(negedge clk);
        wr_frame_start = 1'b0; wr_frame_done = 1'b0;
        rd_frame_start = 1'b0; rd_frame_done = 1'b0;
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        #2;
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_buffer_manager.md
FRAME_BUFFER_MANAGER -- requirements
Module: frame_buffer_manager

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of buffer 0.
REQ-002 SHALL have parameter FRAME_BYTES, default 32'h000E_1000 (640x480x3), byte stride between buffers.
REQ-003 SHALL have port clk, input, 1 bit: single clock for all logic; one clock domain, no CDC inside.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port enable, input, 1 bit: CPU enable; 0 holds the block in the reset state.
REQ-006 SHALL have port wr_frame_start, input, 1 bit: one-cycle pulse, HDMI capture begins a frame.
REQ-007 SHALL have port wr_frame_done, input, 1 bit: one-cycle pulse, HDMI capture has finished writing a frame.
REQ-008 SHALL have port rd_frame_start, input, 1 bit: one-cycle pulse, DSI fetch requests a frame.
REQ-009 SHALL have port rd_frame_done, input, 1 bit: one-cycle pulse, DSI fetch has finished a frame.
REQ-010 SHALL have port wr_base_addr, output, 32 bits: base address for the capture writer.
REQ-011 SHALL have port wr_base_valid, output, 1 bit: wr_base_addr is valid for the current frame.
REQ-012 SHALL have port rd_base_addr, output, 32 bits: base address for the DSI reader.
REQ-013 SHALL have port rd_base_valid, output, 1 bit: rd_base_addr holds a completed frame.
REQ-014 SHALL have port rd_repeat, output, 1 bit: the current read frame is the same frame as the previous read.
REQ-015 SHALL have port dropped_cnt, output, 16 bits: count of completed frames overwritten before being read; saturates.

Function
REQ-016 SHALL implement triple buffering with indices wr_idx, ready_idx and rd_idx; the three SHALL be pairwise distinct at all times.
REQ-017 SHALL carry a fresh flag (ready_idx holds an unread frame) and a have_frame flag (at least one frame completed since reset).
REQ-018 Writer FSM SHALL have states W_IDLE and W_BUSY: wr_frame_start moves to W_BUSY; wr_frame_done in W_BUSY moves to W_IDLE.
REQ-019 On wr_frame_done in W_BUSY: swap wr_idx and ready_idx, set fresh and have_frame; if fresh was already 1, increment dropped_cnt (saturate at 16'hFFFF).
REQ-020 wr_frame_start in W_BUSY SHALL abort the frame: same wr_idx, stay in W_BUSY, no swap.
REQ-021 wr_frame_done in W_IDLE SHALL be ignored.
REQ-022 Reader FSM SHALL have states R_IDLE and R_BUSY.
REQ-023 On rd_frame_start with fresh=1: swap rd_idx and ready_idx, clear fresh, rd_repeat=0.
REQ-024 On rd_frame_start with fresh=0: keep rd_idx, rd_repeat=1.
REQ-025 The reader FSM SHALL enter R_BUSY on every rd_frame_start.
REQ-026 rd_frame_start in R_BUSY SHALL be treated as an implicit rd_frame_done followed by a new start.
REQ-027 rd_frame_done SHALL move the reader FSM to R_IDLE.
REQ-028 rd_base_valid SHALL equal have_frame, sampled at rd_frame_start.
REQ-029 When wr_frame_done and rd_frame_start occur in the same cycle, the write swap SHALL be applied first, so the reader receives the frame just completed with rd_repeat=0.
REQ-030 Addresses SHALL equal BASE_ADDR + idx*FRAME_BYTES using three precomputed constants (no multiplier), 32-bit with wrap-around.
REQ-031 Address outputs SHALL be registered and updated 1 cycle after the triggering pulse.
REQ-032 wr_base_valid SHALL be 1 in W_BUSY and 0 otherwise.
REQ-033 With enable=0, all pulses SHALL be ignored and the state SHALL be forced to reset values.
REQ-034 dropped_cnt SHALL be retained while enable=0.

Reset
REQ-035 On rst_n=0 at a clk edge: wr_idx=0, ready_idx=1, rd_idx=2.
REQ-036 On reset: fresh=0 and have_frame=0.
REQ-037 On reset: both FSMs go to IDLE.
REQ-038 On reset: wr_base_addr=BASE_ADDR, rd_base_addr=BASE_ADDR+2*FRAME_BYTES.
REQ-039 On reset: wr_base_valid=0, rd_base_valid=0, rd_repeat=0, dropped_cnt=0.
REQ-040 Reset asserted mid-frame SHALL take effect on the next edge without waiting for done pulses.

Structure
REQ-041 The shared package SHALL hold the writer and reader FSM state enums, a 2-bit buffer-index typedef and the reset index constants.
REQ-042 The block SHALL be a single module; no sub-module is required.

Verification
REQ-043 Reset, enable=1, wr_frame_start -> wr_base_addr=0x0000_0000 and wr_base_valid=1 one cycle later.
REQ-044 Write frame, then rd_frame_start -> rd_base_addr=0x0000_0000, rd_base_valid=1, rd_repeat=0; next wr_frame_start -> wr_base_addr=0x000E_1000.
REQ-045 Three wr_frame_done with no read -> dropped_cnt=2; then rd_frame_start -> rd_repeat=0 and the reader gets the last completed buffer.
REQ-046 rd_frame_start before any frame completes -> rd_base_valid=0, rd_repeat=1, rd_base_addr=0x001C_2000.
REQ-047 wr_frame_done and rd_frame_start in the same cycle -> reader gets the buffer just written with rd_repeat=0; indices remain distinct.
REQ-048 rst_n=0 during W_BUSY/R_BUSY -> all outputs at reset values next cycle; dropped_cnt=0.
